axis_burst_packetizer: RTL
==========================

// Module: axis_burst_packetizer
// PURPOSE
//  Sits directly downstream of the AXIS event FIFO and feeds the DMA (S2MM) write channel.
//  Groups the untyped 64-bit event word stream into fixed-length bursts of BURST_LEN beats and asserts m_axis_tlast on the final beat.
//  Closes a partial burst with PAD_WORD beats on timeout or on an explicit flush, so sparse sensor traffic still reaches memory.
// PARAMETERS
//  AXIS_BUS_WIDTH  64    data width, both sides
//  BURST_LEN       16    beats per burst; >=2, power of two not required
//  TIMEOUT_CYCLES  1024  idle cycles inside a partial burst before padding starts; >=1
//  PAD_WORD        '0    data value driven on pad beats
// PORTS
//  m_axi_aclk        in   1                     clock
//  m_axi_areset      in   1                     synchronous reset, active-high
//  s_axis_tdata      in   AXIS_BUS_WIDTH        event word from the FIFO
//  s_axis_tvalid     in   1                     upstream valid
//  s_axis_tready     out  1                     upstream ready
//  m_axis_tdata      out  AXIS_BUS_WIDTH        burst data
//  m_axis_tvalid     out  1                     downstream valid
//  m_axis_tready     in   1                     downstream ready
//  m_axis_tlast      out  1                     last beat of burst
//  m_axis_tuser      out  1                     1 = pad beat, 0 = real event
//  i_flush           in   1                     one-cycle pulse: close the current partial burst
//  o_beat_count      out  $clog2(BURST_LEN+1)   beats already emitted or accepted into the current burst
//  o_burst_count     out  32                    completed bursts, wraps at 2^32
// BEHAVIOUR
//  Reset: all m_axis_* = 0, s_axis_tready = 0, counters = 0, state = IDLE.
//    Reset mid-burst discards the partial burst; no tlast is emitted.
//  Output stage: single registered slice, 1-cycle latency s->m.
//    Holds data while m_axis_tvalid && !m_axis_tready.
//    m_axis_* never change while stalled.
//  s_axis_tready = (state != PAD) && (!m_axis_tvalid || m_axis_tready); registered-path only, no comb loop to s_axis_tvalid.
//  Accept = s_axis_tvalid && s_axis_tready; emit = m_axis_tvalid && m_axis_tready.
//  FSM:
//   IDLE: beat_cnt = 0. Accept -> load beat, beat_cnt = 1, go FILL. i_flush ignored in IDLE.
//   FILL: each accept loads a beat and increments beat_cnt.
//    When beat_cnt == BURST_LEN-1 on an accept, the loaded beat carries tlast=1, beat_cnt -> 0, and the state goes IDLE.
//    The burst counter increments when that beat is emitted.
//    Timeout: tmo_cnt clears on every accept and increments each FILL cycle without an accept.
//    At tmo_cnt == TIMEOUT_CYCLES-1, or i_flush, go PAD.
//    i_flush in the same cycle as an accept: the beat counts first. If that beat completes the burst, go IDLE with no pad; otherwise go PAD.
//   PAD: s_axis_tready = 0. Load PAD_WORD with tuser=1 whenever the slice is free.
//    The final pad beat (beat_cnt == BURST_LEN-1) has tlast=1; then go IDLE.
//    i_flush during PAD is ignored.
//  Every burst is exactly BURST_LEN beats, and tlast appears only on beat BURST_LEN.
//  Pads are contiguous at the tail of a burst and never interleave with real beats.
//  Downstream backpressure freezes the FSM's load step but not tmo_cnt.
//  Timeout may therefore fire while stalled; padding simply waits for the slice.
//  o_beat_count = beat_cnt (registered). o_burst_count increments on emit of a tlast beat.
// STRUCTURE
//  axis_pkg: typedef enum logic [1:0] {IDLE, FILL, PAD} pkt_state_t; shared AXIS width localparams.
//  Sub-module axis_reg_slice (data, last, user; valid/ready; 1 entry) instantiated for the output stage.
//  Top holds the FSM, beat_cnt, tmo_cnt ($clog2(TIMEOUT_CYCLES+1) bits) and burst_cnt.
// TESTING  (BURST_LEN=4, TIMEOUT_CYCLES=8 in the bench)
//  Full burst: 4 accepts, m_axis_tready=1 -> 4 beats, data equal to the inputs, tlast only on beat 4, tuser=0, o_burst_count=1.
//  Timeout: 2 accepts then idle -> after 8 idle cycles, beats 3-4 = PAD_WORD, tuser=1, tlast on beat 4, s_axis_tready=0 during pad.
//  Flush with last beat: 3 accepts, then i_flush together with the 4th accept -> no pad beats, tlast on beat 4, returns to IDLE.
//  Backpressure: random m_axis_tready over 100 words -> data order preserved, m_axis_* stable while stalled, tlast every 4th beat.
//  Reset mid-burst: 2 accepts, then m_axi_areset=1 for 1 cycle -> all outputs 0; the next 4 words form a clean burst with o_burst_count counting from 0.
//  Flush in IDLE: i_flush with no data -> no output beats, state stays IDLE.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXIS burst packetizer.
// Imported by the packetizer top and its output register slice.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2
  } pkt_state_t;

  localparam int unsigned AXIS_DW  = 64;
  localparam int unsigned AXIS_BL  = 16;
  localparam int unsigned AXIS_TMO = 1024;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXIS register slice carrying data, last and user.
// Holds its contents while the consumer stalls.
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int unsigned DW = AXIS_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  input  logic          in_user_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          out_user_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  logic [DW-1:0] data_q;
  logic          last_q;
  logic          user_q;
  logic          valid_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_user_o  = user_q;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      data_q  <= in_data_i;
      last_q  <= in_last_i;
      user_q  <= in_user_i;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_burst_packetizer.sv
// Groups an AXIS event stream into fixed-length bursts with tlast,
// padding partial bursts on timeout or flush.
module axis_burst_packetizer
  import axis_pkg::*;
#(
  parameter int unsigned AXIS_BUS_WIDTH = AXIS_DW,
  parameter int unsigned BURST_LEN      = AXIS_BL,
  parameter int unsigned TIMEOUT_CYCLES = AXIS_TMO,
  parameter logic [AXIS_BUS_WIDTH-1:0] PAD_WORD = '0
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic [AXIS_BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AXIS_BUS_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  input  logic                      i_flush,
  output logic [$clog2(BURST_LEN+1)-1:0] o_beat_count,
  output logic [31:0]               o_burst_count
);

  localparam int unsigned BCW = cnt_w(BURST_LEN);
  localparam int unsigned TW  = cnt_w(TIMEOUT_CYCLES);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  pkt_state_t state_q, state_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [31:0]    burst_q, burst_d;

  logic                      slice_rdy;
  logic                      ld_valid;
  logic [AXIS_BUS_WIDTH-1:0] ld_data;
  logic                      ld_last;
  logic                      ld_user;
  logic                      accept;
  logic                      emit_last;

  assign s_axis_tready = !m_axi_areset && (state_q != PAD) && slice_rdy;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign emit_last     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign o_beat_count  = beat_q;
  assign o_burst_count = burst_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    ld_valid = 1'b0;
    ld_data  = s_axis_tdata;
    ld_last  = 1'b0;
    ld_user  = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        tmo_d  = '0;
        if (accept) begin
          ld_valid = 1'b1;
          beat_d   = BCW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          ld_valid = 1'b1;
          tmo_d    = '0;
          if (beat_q == BEAT_LAST) begin
            ld_last = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BCW'(1);
            if (i_flush) state_d = PAD;
          end
        end else if (i_flush || tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = PAD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PAD: begin
        tmo_d   = '0;
        ld_data = PAD_WORD;
        ld_user = 1'b1;
        if (slice_rdy) begin
          ld_valid = 1'b1;
          if (beat_q == BEAT_LAST) begin
            ld_last = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      default: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (emit_last) burst_d = burst_q + 32'd1;
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tmo_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      burst_q <= burst_d;
    end
  end

  axis_reg_slice #(
    .DW(AXIS_BUS_WIDTH)
  ) u_out (
    .clk_i      (m_axi_aclk),
    .rst_i      (m_axi_areset),
    .in_data_i  (ld_data),
    .in_last_i  (ld_last),
    .in_user_i  (ld_user),
    .in_valid_i (ld_valid),
    .in_ready_o (slice_rdy),
    .out_data_o (m_axis_tdata),
    .out_last_o (m_axis_tlast),
    .out_user_o (m_axis_tuser),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready)
  );

endmodule
